// File: rtl/fifo_stream_drain_if.sv
// Valid/ready stream carrying one DATA_WIDTH word per accepted beat.
// The master drives valid/data and the slave drives ready.
interface fifo_stream_drain_if #(
   parameter int unsigned DATA_WIDTH = 8
) ();
   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fifo_stream_drain.sv
// Turns a synchronous_fifo read port (r_en/empty, 1-cycle data) into a valid/ready stream via a
// small skid buffer. Optional accepted-beat counter on beat_cnt_o when DRAIN_BEAT_CNT_EN is defined.
module fifo_stream_drain #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned OUT_DEPTH  = 2,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  drain_en_i,
   input  logic                  fifo_empty_i,
   input  logic [DATA_WIDTH-1:0] fifo_data_i,
   output logic                  fifo_r_en_o,
   fifo_stream_drain_if.master   m_if,
   output logic                  busy_o
`ifdef DRAIN_BEAT_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]  beat_cnt_o
`endif
);

   localparam int unsigned PtrW = $clog2(OUT_DEPTH);
   localparam int unsigned CntW = $clog2(OUT_DEPTH + 1);
   localparam logic [CntW:0] OccLimit = (CntW + 1)'(OUT_DEPTH);

   typedef logic [PtrW-1:0] ptr_t;

   if (OUT_DEPTH < 2 || CNT_WIDTH == 0) begin : g_param_check
      $error("fifo_stream_drain: OUT_DEPTH must be >= 2 and CNT_WIDTH must be > 0");
   end

   logic [DATA_WIDTH-1:0] buf_q [OUT_DEPTH];
   logic [CntW-1:0]       count_q, count_d;
   ptr_t                  head_q, head_d;
   ptr_t                  tail_q, tail_d;
   logic                  inflight_q;
   logic                  pop;
   logic [CntW:0]         occ;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(OUT_DEPTH - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   assign pop = m_if.valid & m_if.ready;

   // Occupancy after this edge if no read were issued; m_ready -> fifo_r_en is deliberate so
   // a full buffer that is being popped can still keep one beat per cycle flowing.
   assign occ = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q} - {{CntW{1'b0}}, pop};
   assign fifo_r_en_o = drain_en_i & ~fifo_empty_i & (occ < OccLimit);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (inflight_q) tail_d = ptr_inc(tail_q);
      if (pop)        head_d = ptr_inc(head_q);
      unique case ({inflight_q, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         inflight_q <= 1'b0;
         for (int unsigned i = 0; i < OUT_DEPTH; i++) buf_q[i] <= '0;
      end else begin
         count_q    <= count_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         inflight_q <= fifo_r_en_o;
         if (inflight_q) buf_q[tail_q] <= fifo_data_i;
      end
   end

   assign m_if.valid = (count_q != '0);
   assign m_if.data  = buf_q[head_q];
   assign busy_o     = (count_q != '0) | inflight_q;

`ifdef DRAIN_BEAT_CNT_EN
   logic [CNT_WIDTH-1:0] beat_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt_q <= '0;
      end else if (pop) begin
         beat_cnt_q <= beat_cnt_q + CNT_WIDTH'(1);
      end
   end

   assign beat_cnt_o = beat_cnt_q;
`endif

endmodule
